// File: rtl/gamepad_pkg.sv
// rtl/gamepad_pkg.sv - state and repeat-phase encodings for the gamepad debouncer
package gamepad_pkg;

    // Per-channel debounce states; level is high in PRESSED and DISARMING
    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        DISARMING = 2'd3
    } state_t;

    // Auto-repeat phase: waiting for the first repeat, or repeating at the rate
    typedef enum logic {
        DELAY = 1'b0,
        RATE  = 1'b1
    } phase_t;

endpackage

// File: rtl/gamepad_debounce_n_if.sv
// rtl/gamepad_debounce_n_if.sv - raw pin and debounced event bundle
interface gamepad_debounce_n_if #(
    parameter int CHANNELS = 6
);

    logic [CHANNELS-1:0] raw_in;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press_pulse;
    logic [CHANNELS-1:0] release_pulse;
    logic [CHANNELS-1:0] rep_pulse;
    logic                any_press;

    // Pin side drives raw_in and consumes the debounced events
    modport master (
        output raw_in,
        input  level, press_pulse, release_pulse, rep_pulse, any_press
    );

    // Debouncer side
    modport slave (
        input  raw_in,
        output level, press_pulse, release_pulse, rep_pulse, any_press
    );

endinterface

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one button channel: synchroniser, debounce FSM, auto-repeat
module debounce_chan
    import gamepad_pkg::*;
#(
    parameter int CNT_W      = 10,
    parameter int ACTIVE_LOW = 1,
    parameter int REPEAT_EN  = 1,
    parameter int REP_W      = 16,
    parameter int REP_DELAY  = 40000,
    parameter int REP_RATE   = 8000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic rep_pulse,
    output logic press_next
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REP_RATE - 1);
    localparam logic             POL        = 1'(ACTIVE_LOW != 0);
    localparam logic             REP_ON     = 1'(REPEAT_EN != 0);

    logic             sync1;
    logic             s;
    state_t           state, state_d;
    phase_t           phase, phase_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [REP_W-1:0] rcnt, rcnt_d;
    logic             release_next;
    logic             rep_next;
    logic             rep_hit;

    // Polarity-normalise and bring the asynchronous pin into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw ^ POL;
            s     <= sync1;
        end
    end

    // Repeat compare depends on which phase we are in
    assign rep_hit = (phase == DELAY) ? (rcnt == DELAY_LAST) : (rcnt == RATE_LAST);

    // Next-state, counter and pulse decode
    always_comb begin
        state_d      = state;
        phase_d      = phase;
        cnt_d        = cnt;
        rcnt_d       = rcnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        rep_next     = 1'b0;
        case (state)
            RELEASED: begin
                if (s) begin
                    state_d = ARMING;
                    cnt_d   = '0;
                end
            end
            ARMING: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (cnt == CNT_MAX) begin
                    state_d    = PRESSED;
                    press_next = 1'b1;
                    rcnt_d     = '0;
                    phase_d    = DELAY;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = DISARMING;
                    cnt_d   = '0;
                end else if (rep_hit) begin
                    rep_next = REP_ON;
                    rcnt_d   = '0;
                    phase_d  = RATE;
                end else begin
                    rcnt_d = rcnt + REP_W'(1);
                end
            end
            DISARMING: begin
                // rcnt stays frozen here so a short glitch only delays the repeat cadence
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt == CNT_MAX) begin
                    state_d      = RELEASED;
                    release_next = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RELEASED;
            phase         <= DELAY;
            cnt           <= '0;
            rcnt          <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            rep_pulse     <= 1'b0;
        end else begin
            state         <= state_d;
            phase         <= phase_d;
            cnt           <= cnt_d;
            rcnt          <= rcnt_d;
            level         <= (state_d == PRESSED) || (state_d == DISARMING);
            press_pulse   <= press_next;
            release_pulse <= release_next;
            rep_pulse     <= rep_next;
        end
    end

endmodule

// File: rtl/gamepad_debounce_n.sv
// rtl/gamepad_debounce_n.sv - multi-channel gamepad button debouncer top
module gamepad_debounce_n
    import gamepad_pkg::*;
#(
    parameter int CHANNELS   = 6,
    parameter int CNT_W      = 10,
    parameter int ACTIVE_LOW = 1,
    parameter int REPEAT_EN  = 1,
    parameter int REP_W      = 16,
    parameter int REP_DELAY  = 40000,
    parameter int REP_RATE   = 8000
) (
    input  logic                 clk,
    input  logic                 rst,
    gamepad_debounce_n_if.slave  bus
);

    logic [CHANNELS-1:0] level_v;
    logic [CHANNELS-1:0] press_v;
    logic [CHANNELS-1:0] release_v;
    logic [CHANNELS-1:0] rep_v;
    logic [CHANNELS-1:0] press_next_v;
    logic                any_press_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .CNT_W      (CNT_W),
            .ACTIVE_LOW (ACTIVE_LOW),
            .REPEAT_EN  (REPEAT_EN),
            .REP_W      (REP_W),
            .REP_DELAY  (REP_DELAY),
            .REP_RATE   (REP_RATE)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .raw           (bus.raw_in[i]),
            .level         (level_v[i]),
            .press_pulse   (press_v[i]),
            .release_pulse (release_v[i]),
            .rep_pulse     (rep_v[i]),
            .press_next    (press_next_v[i])
        );
    end

    // any_press is built from the pulse D-inputs so it lands in the same cycle as press_pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_next_v;
        end
    end

    assign bus.level         = level_v;
    assign bus.press_pulse   = press_v;
    assign bus.release_pulse = release_v;
    assign bus.rep_pulse     = rep_v;
    assign bus.any_press     = any_press_q;

endmodule

// File: tb/tb_gamepad_debounce_n.sv
// tb/tb_gamepad_debounce_n.sv - directed vector bench for gamepad_debounce_n
module tb_gamepad_debounce_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] raw = 6'h3F;

    int n_pass = 0;
    int n_total = 0;
    int rep1_cnt = 0;
    int repb_cnt = 0;
    int rel0_cnt = 0;
    int rel5_cnt = 0;
    int press2_cnt = 0;
    int viol_cnt = 0;

    gamepad_debounce_n_if #(.CHANNELS(6)) ia ();
    gamepad_debounce_n_if #(.CHANNELS(6)) ib ();

    assign ia.raw_in = raw;
    assign ib.raw_in = raw;

    gamepad_debounce_n #(
        .CHANNELS(6), .CNT_W(3), .ACTIVE_LOW(1), .REPEAT_EN(1),
        .REP_W(16), .REP_DELAY(20), .REP_RATE(5)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    gamepad_debounce_n #(
        .CHANNELS(6), .CNT_W(3), .ACTIVE_LOW(1), .REPEAT_EN(0),
        .REP_W(16), .REP_DELAY(20), .REP_RATE(5)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  raw;
        int          cyc;
        logic [24:0] exp;
    } vec_t;

    localparam logic [24:0] REP_MASK = {6'h00, 6'h00, 6'h00, 6'h3F, 1'b0};

    function automatic logic [24:0] ex(input logic [5:0] lvl, input logic [5:0] prs,
                                       input logic [5:0] rel, input logic [5:0] rep,
                                       input logic any);
        return {lvl, prs, rel, rep, any};
    endfunction

    function automatic logic [24:0] snap_a();
        return {ia.level, ia.press_pulse, ia.release_pulse, ia.rep_pulse, ia.any_press};
    endfunction

    function automatic logic [24:0] snap_b();
        return {ib.level, ib.press_pulse, ib.release_pulse, ib.rep_pulse, ib.any_press};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Event counters and per-cycle invariants, sampled away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            if (ia.rep_pulse[1]) rep1_cnt <= rep1_cnt + 1;
            if (ib.rep_pulse != 6'h0) repb_cnt <= repb_cnt + 1;
            if (ia.release_pulse[0]) rel0_cnt <= rel0_cnt + 1;
            if (ia.release_pulse[5]) rel5_cnt <= rel5_cnt + 1;
            if (ia.press_pulse[2]) press2_cnt <= press2_cnt + 1;
            if (((ia.rep_pulse & (ia.press_pulse | ia.release_pulse)) != 6'h0) ||
                (ia.any_press !== (|ia.press_pulse)))
                viol_cnt <= viol_cnt + 1;
        end
    end

    // Directed stimulus
    initial begin
        vec_t vt[24];

        vt[0]  = '{6'h3F, 50, ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)};
        vt[1]  = '{6'h3F, 50, ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)};
        vt[2]  = '{6'h3E, 10, ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)};
        vt[3]  = '{6'h3E,  1, ex(6'h01, 6'h01, 6'h00, 6'h00, 1'b1)};
        vt[4]  = '{6'h3E,  1, ex(6'h01, 6'h00, 6'h00, 6'h00, 1'b0)};
        vt[5]  = '{6'h3F, 10, ex(6'h01, 6'h00, 6'h00, 6'h00, 1'b0)};
        vt[6]  = '{6'h3F,  1, ex(6'h00, 6'h00, 6'h01, 6'h00, 1'b0)};
        vt[7]  = '{6'h3F,  1, ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)};
        for (int k = 0; k < 4; k++) begin
            vt[8 + 2*k] = '{6'h3B, 5, ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)};
            vt[9 + 2*k] = '{6'h3F, 5, ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)};
        end
        vt[16] = '{6'h3B, 10, ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)};
        vt[17] = '{6'h3B,  1, ex(6'h04, 6'h04, 6'h00, 6'h00, 1'b1)};
        vt[18] = '{6'h3B,  1, ex(6'h04, 6'h00, 6'h00, 6'h00, 1'b0)};
        vt[19] = '{6'h3F,  4, ex(6'h04, 6'h00, 6'h00, 6'h00, 1'b0)};
        vt[20] = '{6'h3B,  3, ex(6'h04, 6'h00, 6'h00, 6'h00, 1'b0)};
        vt[21] = '{6'h3F, 10, ex(6'h04, 6'h00, 6'h00, 6'h00, 1'b0)};
        vt[22] = '{6'h3F,  1, ex(6'h00, 6'h00, 6'h04, 6'h00, 1'b0)};
        vt[23] = '{6'h3F,  1, ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)};

        step(3);
        chk("reset_a", 32'(snap_a()), 32'(25'h0));
        chk("reset_b", 32'(snap_b()), 32'(25'h0));
        rst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            raw = vt[i].raw;
            step(vt[i].cyc);
            chk($sformatf("vec%0d_a", i), 32'(snap_a()), 32'(vt[i].exp));
            chk($sformatf("vec%0d_b", i), 32'(snap_b()), 32'(vt[i].exp & ~REP_MASK));
        end

        // Auto-repeat on channel 1: first after 20, then every 5, glitch shifts cadence by 5
        raw = 6'h3D;
        step(10);
        chk("rep_arm", 32'(snap_a()), 32'(ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)));
        step(1);
        chk("rep_press", 32'(snap_a()), 32'(ex(6'h02, 6'h02, 6'h00, 6'h00, 1'b1)));
        step(19);
        chk("rep_before_first", 32'(snap_a()), 32'(ex(6'h02, 6'h00, 6'h00, 6'h00, 1'b0)));
        step(1);
        chk("rep_first", 32'(snap_a()), 32'(ex(6'h02, 6'h00, 6'h00, 6'h02, 1'b0)));
        chk("rep_b_off", 32'(snap_b()), 32'(ex(6'h02, 6'h00, 6'h00, 6'h00, 1'b0)));
        step(4);
        chk("rep_before_second", 32'(snap_a()), 32'(ex(6'h02, 6'h00, 6'h00, 6'h00, 1'b0)));
        step(1);
        chk("rep_second", 32'(snap_a()), 32'(ex(6'h02, 6'h00, 6'h00, 6'h02, 1'b0)));
        raw = 6'h3F;
        step(4);
        chk("rep_glitch_hold", 32'(snap_a()), 32'(ex(6'h02, 6'h00, 6'h00, 6'h00, 1'b0)));
        raw = 6'h3D;
        step(5);
        chk("rep_shift_quiet", 32'(snap_a()), 32'(ex(6'h02, 6'h00, 6'h00, 6'h00, 1'b0)));
        step(1);
        chk("rep_third", 32'(snap_a()), 32'(ex(6'h02, 6'h00, 6'h00, 6'h02, 1'b0)));
        step(5);
        chk("rep_fourth", 32'(snap_a()), 32'(ex(6'h02, 6'h00, 6'h00, 6'h02, 1'b0)));
        raw = 6'h3F;
        step(10);
        chk("rep_rel_wait", 32'(snap_a()), 32'(ex(6'h02, 6'h00, 6'h00, 6'h00, 1'b0)));
        step(1);
        chk("rep_release", 32'(snap_a()), 32'(ex(6'h00, 6'h00, 6'h02, 6'h00, 1'b0)));
        step(1);

        // Channels 0 and 5 together, then async reset between edges while held
        raw = 6'h1E;
        step(10);
        chk("multi_wait", 32'(snap_a()), 32'(ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)));
        step(1);
        chk("multi_press", 32'(snap_a()), 32'(ex(6'h21, 6'h21, 6'h00, 6'h00, 1'b1)));
        step(3);
        chk("multi_hold", 32'(snap_a()), 32'(ex(6'h21, 6'h00, 6'h00, 6'h00, 1'b0)));
        #2 rst = 1'b0;
        #1;
        chk("async_reset_drop", 32'(snap_a()), 32'(25'h0));
        @(negedge clk);
        chk("async_reset_hold", 32'(snap_a()), 32'(25'h0));
        rst = 1'b1;
        step(10);
        chk("requal_wait", 32'(snap_a()), 32'(ex(6'h00, 6'h00, 6'h00, 6'h00, 1'b0)));
        step(1);
        chk("requal_press", 32'(snap_a()), 32'(ex(6'h21, 6'h21, 6'h00, 6'h00, 1'b1)));
        step(1);
        #1;

        chk("rep1_count", 32'(rep1_cnt), 32'd4);
        chk("b_rep_count", 32'(repb_cnt), 32'd0);
        chk("rel0_count", 32'(rel0_cnt), 32'd1);
        chk("rel5_count", 32'(rel5_cnt), 32'd0);
        chk("press2_count", 32'(press2_cnt), 32'd1);
        chk("invariant_viol", 32'(viol_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gamepad_debounce_n.md
Name: gamepad_debounce_n

Overview:
- Parametrised multi-channel debouncer, successor to the per-button debounce used in the gamepad interface.
- Sits between the raw gamepad pins and game control logic.
- Per channel:
  - synchronises the raw pin;
  - debounces both edges symmetrically;
  - produces a clean level, one-cycle press/release pulses and optional auto-repeat pulses for held buttons (menu/cursor movement).

Parameters:
- CHANNELS, 6, number of independent button channels.
- CNT_W, 10, debounce counter width; stable time = 2^CNT_W cycles.
- ACTIVE_LOW, 1, 1 = raw pin low means pressed (inverted on entry); 0 = high means pressed.
- REPEAT_EN, 1, 1 = auto-repeat pulses generated; 0 = rep_pulse tied 0.
- REP_W, 16, width of repeat counters.
- REP_DELAY, 40000, cycles held (after press pulse) before first repeat pulse; 1 to 2^REP_W-1.
- REP_RATE, 8000, cycles between subsequent repeat pulses; 1 to 2^REP_W-1.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset (0 = reset).
- raw_in, in, CHANNELS, raw button pins, asynchronous to clk.
- level, out, CHANNELS, debounced pressed state (1 = pressed).
- press_pulse, out, CHANNELS, 1-cycle pulse on debounced press.
- release_pulse, out, CHANNELS, 1-cycle pulse on debounced release.
- rep_pulse, out, CHANNELS, 1-cycle auto-repeat pulse while held.
- any_press, out, 1, OR of press_pulse, registered alongside it (same cycle).

Behaviour:
- Reset (rst=0, async): sync flops = 0 (not pressed), all states RELEASED, all counters 0, every output 0.
  - Mid-operation reset drops held levels immediately; no release_pulse is emitted.
  - After rst deasserts, a held button re-qualifies from scratch.
- Polarity: s_raw = raw_in XOR {CHANNELS{ACTIVE_LOW}}. Then 2-flop synchroniser gives s.
- Per-channel FSM, counter cnt[CNT_W-1:0], MAX = 2^CNT_W-1:
  - RELEASED: s=1 -> ARMING, cnt<=0.
  - ARMING: s=0 -> RELEASED (bounce rejected, no pulse); s=1 & cnt==MAX -> PRESSED, press_pulse=1 next cycle; else cnt++.
  - PRESSED: s=0 -> DISARMING, cnt<=0; else repeat logic runs.
  - DISARMING: s=1 -> PRESSED (no pulses, repeat counter resumes); s=0 & cnt==MAX -> RELEASED, release_pulse=1 next cycle; else cnt++.
- All outputs are registered. level=1 in PRESSED and DISARMING.
- Latency: raw press sampled at edge 0 and held gives level and press_pulse high after edge 2^CNT_W+2. Release is symmetric.
- A bounce shorter than 2^CNT_W+1 cycles of s never changes level and produces no pulse.
- Repeat counter rcnt[REP_W-1:0], REPEAT_EN=1:
  - Cleared on entry to PRESSED from ARMING.
  - Increments each PRESSED cycle; frozen in DISARMING.
  - First repeat: rcnt reaches REP_DELAY-1 -> rep_pulse next cycle, rcnt<=0, phase<=RATE.
  - In RATE phase: pulse when rcnt==REP_RATE-1, then rcnt<=0.
  - rep_pulse never coincides with press_pulse or release_pulse on the same channel.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- No counter ever wraps. cnt saturates by state exit. rcnt is bounded by REP_DELAY/REP_RATE compares.

Decomposition:
- Package gamepad_pkg holds:
  - the state encoding constants RELEASED=2'd0, ARMING=2'd1, PRESSED=2'd2, DISARMING=2'd3;
  - the repeat phase constants DELAY=1'b0, RATE=1'b1.
- One sub-module, debounce_chan: a single channel containing the synchroniser, FSM, cnt and rcnt, with the same parameters minus CHANNELS.
- The top level instantiates CHANNELS copies in a generate loop and ORs press_pulse into any_press.

Test Plan:
1. Reset/idle: rst=0 then 1, raw_in all 1 (ACTIVE_LOW=1), CNT_W=3 -> all outputs 0 for 100 cycles.
2. Clean press: CNT_W=3, raw_in[0] 1->0 sampled at edge 0 and held -> level[0], press_pulse[0], any_press rise after edge 10; press_pulse[0] lasts exactly 1 cycle.
3. Bounce rejection: CNT_W=3, raw_in[2] low for 5 cycles then high, repeated 4 times -> level[2] stays 0, no pulses; then held low -> press after 10 edges.
4. Release with glitch: a held channel goes high 4 cycles, low 3, then high held -> level stays 1 through the glitch; release_pulse once, 10 edges after the final rising sample.
5. Auto-repeat: REP_DELAY=20, REP_RATE=5, channel held -> rep_pulse 20 cycles after press_pulse, then every 5 cycles; a 4-cycle glitch freezes spacing without extra pulses; REPEAT_EN=0 -> rep_pulse always 0.
6. Async reset mid-hold plus multi-channel: channels 0 and 5 pressed on the same edge -> both press_pulses in the same cycle; rst pulled low between clock edges -> level drops immediately with no release_pulse; re-press after rst=1 -> full re-qualification.
